// File: rtl/canonical_huffman_decoder.sv
// canonical_huffman_decoder: bit-serial canonical Huffman decoder, MSB-first codewords, table-driven.
// Optional out_len port under `HUFF_DEC_LEN_OUT_EN.
module canonical_huffman_decoder #(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 15,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [SYM_W-1:0] cfg_addr,
  input  logic [SYM_W:0]   cfg_data,
  input  logic             dec_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_sym,
  output logic             busy,
  output logic             err
`ifdef HUFF_DEC_LEN_OUT_EN
  ,
  output logic [LEN_W-1:0] out_len
`endif
);
  localparam int CL = MAX_LEN + 1;
  localparam int CW = (CL > SYM_W + 1) ? CL : SYM_W + 1;
  localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAX_LEN);
  localparam logic [SYM_W-1:0] AMAX = SYM_W'(MAX_LEN);
  typedef enum logic [1:0] {S_BIT, S_OUT, S_ERR} state_t;
  state_t r_state, w_next;
  logic [LEN_W-1:0] r_len, w_l;
  logic [MAX_LEN:0] r_code, r_first, w_c, w_f, w_d;
  logic [SYM_W:0] r_index, w_cnt;
  logic [SYM_W:0] r_bl_count [0:MAX_LEN];
  logic [SYM_W-1:0] r_sym_table [0:(1<<SYM_W)-1];
  logic [SYM_W-1:0] r_out_sym, w_sidx;
  logic w_take, w_match, w_cfg_ok, w_addr_ok;
  assign in_ready  = r_state == S_BIT;
  assign out_valid = r_state == S_OUT;
  assign err       = r_state == S_ERR;
  assign busy      = (r_len != '0) || (r_state == S_OUT);
  assign out_sym   = r_out_sym;
  assign w_take    = in_valid && in_ready;
  assign w_l       = r_len + 1'b1;
  assign w_c       = {r_code[MAX_LEN-1:0], in_bit};
  assign w_f       = {r_first[MAX_LEN-1:0], 1'b0};
  assign w_d       = w_c - w_f;
  assign w_cnt     = r_bl_count[w_l];
  // Offset into the current length's run of codes; below the count means a hit.
  assign w_match   = CW'(w_d) < CW'(w_cnt);
  assign w_sidx    = SYM_W'(CW'(r_index) + CW'(w_d));
  assign w_cfg_ok  = cfg_we && (r_state == S_BIT) && (r_len == '0);
  assign w_addr_ok = (cfg_addr != '0) && (cfg_addr <= AMAX);
  always_comb begin
    w_next = r_state;
    if (dec_clr) w_next = S_BIT;
    else if (w_take) w_next = w_match ? S_OUT : ((w_l == LMAX) ? S_ERR : S_BIT);
    else if (out_valid && out_ready) w_next = S_BIT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_BIT;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_len     <= '0;
      r_code    <= '0;
      r_first   <= '0;
      r_index   <= '0;
      r_out_sym <= '0;
      for (int i = 0; i <= MAX_LEN; i++) r_bl_count[i] <= '0;
    end else begin
      if (dec_clr || (w_take && w_match)) begin
        r_len   <= '0;
        r_code  <= '0;
        r_first <= '0;
        r_index <= '0;
      end else if (w_take && (w_l != LMAX)) begin
        r_len   <= w_l;
        r_code  <= w_c;
        r_first <= w_f + CL'(w_cnt);
        r_index <= r_index + w_cnt;
      end
      if (!dec_clr && w_take && w_match) r_out_sym <= r_sym_table[w_sidx];
      if (w_cfg_ok && !cfg_sel && w_addr_ok) r_bl_count[LEN_W'(cfg_addr)] <= cfg_data;
    end
  always_ff @(posedge clk)
    if (!rst && w_cfg_ok && cfg_sel) r_sym_table[cfg_addr] <= cfg_data[SYM_W-1:0];
`ifdef HUFF_DEC_LEN_OUT_EN
  logic [LEN_W-1:0] r_out_len;
  assign out_len = r_out_len;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_out_len <= '0;
    else if (dec_clr) r_out_len <= '0;
    else if (w_take && w_match) r_out_len <= w_l;
`endif
endmodule

// File: tb/tb_canonical_huffman_decoder.sv
// tb_canonical_huffman_decoder: directed and randomized checks against a codebook-level model.
module tb_canonical_huffman_decoder;
  localparam int MAX_LEN = 15;
  logic clk, rst, cfg_we, cfg_sel, dec_clr, in_valid, in_ready, in_bit;
  logic out_valid, out_ready, busy, err;
  logic [7:0] cfg_addr, out_sym;
  logic [8:0] cfg_data;
`ifdef HUFF_DEC_LEN_OUT_EN
  logic [3:0] out_len;
`endif
  int vec, mis, n;
  int cnt [0:MAX_LEN];
  int cv [0:255];
  int cl [0:255];
  int tab [0:255];

  canonical_huffman_decoder dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .dec_clr(dec_clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .busy(busy), .err(err)
`ifdef HUFF_DEC_LEN_OUT_EN
    , .out_len(out_len)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_w(input int sel, input int addr, input int data);
    cfg_we = 1; cfg_sel = sel[0]; cfg_addr = addr[7:0]; cfg_data = data[8:0];
    tick();
    cfg_we = 0;
  endtask

  // Canonical codebook: codes of each length are consecutive, next length starts at (last+1)<<1.
  task automatic build_codes();
    int c;
    c = 0; n = 0;
    for (int l = 1; l <= MAX_LEN; l++) begin
      for (int j = 0; j < cnt[l]; j++) begin
        cv[n] = c; cl[n] = l; c++; n++;
      end
      c = c << 1;
    end
  endtask

  task automatic set_basic();
    for (int l = 0; l <= MAX_LEN; l++) cnt[l] = 0;
    cnt[1] = 1; cnt[2] = 1; cnt[3] = 2;
    tab[0] = 'h41; tab[1] = 'h42; tab[2] = 'h43; tab[3] = 'h44;
    build_codes();
  endtask

  // Complete prefix code grown by randomly splitting leaves of a binary tree.
  task automatic build_rand(input int splits);
    int lens[$];
    int i;
    lens = {1, 1};
    for (int s = 0; s < splits; s++) begin
      i = int'($urandom_range(lens.size() - 1));
      if (lens[i] < MAX_LEN) begin
        lens[i] = lens[i] + 1;
        lens.push_back(lens[i]);
      end
    end
    for (int l = 0; l <= MAX_LEN; l++) cnt[l] = 0;
    foreach (lens[j]) cnt[lens[j]]++;
    build_codes();
    for (int k = 0; k < n; k++) tab[k] = int'($urandom_range(255));
  endtask

  task automatic load_table();
    for (int l = 1; l <= MAX_LEN; l++) cfg_w(0, l, cnt[l]);
    for (int k = 0; k < n; k++) cfg_w(1, k, tab[k]);
  endtask

  task automatic send_code(input int val, input int len, input int gap);
    for (int i = len - 1; i >= 0; i--) begin
      repeat ($urandom_range(gap)) begin in_valid = 0; tick(); end
      chk("in_ready_bit", in_ready, 1);
      in_valid = 1; in_bit = val[i];
      tick();
      in_valid = 0;
      if (i > 0) chk("early_valid", out_valid, 0);
    end
  endtask

  task automatic expect_sym(input string tag, input int k, input int hold);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sym"}, out_sym, tab[k]);
`ifdef HUFF_DEC_LEN_OUT_EN
    chk({tag, "_len"}, out_len, cl[k]);
`endif
    out_ready = 0;
    repeat (hold) begin
      tick();
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_sym"}, out_sym, tab[k]);
      chk({tag, "_hold_ready"}, in_ready, 0);
    end
    out_ready = 1;
    tick();
    chk({tag, "_release_valid"}, out_valid, 0);
    chk({tag, "_release_ready"}, in_ready, 1);
  endtask

  task automatic pulse_clr();
    dec_clr = 1;
    tick();
    dec_clr = 0;
    chk("clr_err", err, 0);
    chk("clr_ready", in_ready, 1);
    chk("clr_busy", busy, 0);
  endtask

  initial begin
    vec = 0; mis = 0;
    rst = 1; cfg_we = 0; cfg_sel = 0; cfg_addr = 0; cfg_data = 0;
    dec_clr = 0; in_valid = 0; in_bit = 0; out_ready = 1;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sym", out_sym, 0);
    chk("rst_ready", in_ready, 1);
`ifdef HUFF_DEC_LEN_OUT_EN
    chk("rst_len", out_len, 0);
`endif
    rst = 0;
    tick();

    // basic decode
    set_basic(); load_table();
    for (int k = 0; k < 4; k++) begin
      send_code(cv[k], cl[k], 0);
      expect_sym("basic", k, 0);
    end

    // backpressure
    send_code(cv[1], cl[1], 0);
    expect_sym("bp", 1, 5);

    // error path
    for (int l = 0; l <= MAX_LEN; l++) cnt[l] = 0;
    build_codes(); load_table();
    send_code(32'h7fff, 15, 0);
    chk("err_set", err, 1);
    chk("err_ready", in_ready, 0);
    chk("err_valid", out_valid, 0);
    in_valid = 1; in_bit = 0;
    tick(); tick();
    in_valid = 0;
    chk("err_sticky", err, 1);
    chk("err_sticky_valid", out_valid, 0);
    pulse_clr();
    set_basic(); load_table();
    for (int k = 0; k < 4; k++) begin
      send_code(cv[k], cl[k], 0);
      expect_sym("after_err", k, 0);
    end

    // idle gaps inside "110"
    in_valid = 1; in_bit = 1; tick();
    in_valid = 0; tick();
    chk("gap_busy0", busy, 1);
    chk("gap_ready0", in_ready, 1);
    tick();
    chk("gap_busy1", busy, 1);
    in_valid = 1; in_bit = 1; tick();
    in_bit = 0; tick();
    in_valid = 0;
    expect_sym("gap", 2, 0);

    // config guard: write dropped while busy
    in_valid = 1; in_bit = 1; tick();
    in_valid = 0;
    cfg_w(0, 3, 0);
    send_code(2, 2, 0);
    expect_sym("guard", 2, 0);
    cfg_w(0, 3, 0);
    send_code(7, 3, 0);
    chk("guard_nomatch", out_valid, 0);
    chk("guard_busy", busy, 1);
    chk("guard_ready", in_ready, 1);
    pulse_clr();
    load_table();
    // write coinciding with the first bit uses the old count
    cfg_we = 1; cfg_sel = 0; cfg_addr = 1; cfg_data = 0;
    in_valid = 1; in_bit = 0;
    tick();
    cfg_we = 0; in_valid = 0;
    expect_sym("coincide", 0, 0);
    send_code(0, 1, 0);
    chk("coincide_new", out_valid, 0);
    chk("coincide_busy", busy, 1);
    pulse_clr();

    // async reset mid-codeword
    load_table();
    send_code(3, 2, 0);
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    #1 rst = 0;
    tick();
    send_code(0, 1, 0);
    chk("arst_counts", out_valid, 0);
    chk("arst_counts_busy", busy, 1);
    pulse_clr();
    load_table();
    send_code(cv[0], cl[0], 0);
    expect_sym("arst_reload", 0, 0);

    // randomized codebooks and streams
    for (int r = 0; r < 5; r++) begin
      build_rand(int'($urandom_range(1, 40)));
      load_table();
      for (int t = 0; t < 20; t++) begin
        int k;
        k = int'($urandom_range(n - 1));
        send_code(cv[k], cl[k], 2);
        expect_sym("rand", k, int'($urandom_range(2)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
